// File: rtl/mcpu_soc_mmio_bridge.sv
// Registered bridge between the core's uncached MMIO port and the SoC MMIO decoder.
// It accepts one access at a time and holds the address on the decoder for SETTLE_CYCLES.
// On the last cycle it pulses wren and samples data_out. The response is held until the core accepts it.
module mcpu_soc_mmio_bridge #(
  parameter int          SETTLE_CYCLES = 1,
  parameter int          MAX_DEV       = 6,
  parameter logic [31:0] ERR_RDATA     = 32'h0
) (
  input  logic        clkrst_core_clk,
  input  logic        clkrst_core_rst_n,
  input  logic        cpu2mmio_valid,
  output logic        cpu2mmio_ready,
  input  logic [28:0] cpu2mmio_addr,
  input  logic [3:0]  cpu2mmio_wren,
  input  logic [31:0] cpu2mmio_wdata,
  output logic        mmio2cpu_rvalid,
  input  logic        mmio2cpu_rready,
  output logic [31:0] mmio2cpu_rdata,
  output logic        mmio2cpu_err,
  output logic [28:0] mmio_addr,
  output logic [3:0]  mmio_wren,
  output logic [31:0] mmio_data_in,
  input  logic [31:0] mmio_data_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0]  CNT_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [18:0] MAX_SLOT = 19'(MAX_DEV);

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  wren_q;
  logic        map_err;
  logic        slot_err;

  // Device slot is byte address [30:12], i.e. word address [28:10]
  assign slot_err = (cpu2mmio_addr[28:10] > MAX_SLOT);

  // Request/response FSM. All outputs are registered. wren is launched one edge early,
  // so that it is high exactly on the final settle cycle.
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      state           <= IDLE;
      cnt             <= 4'd0;
      wren_q          <= 4'h0;
      map_err         <= 1'b0;
      cpu2mmio_ready  <= 1'b0;
      mmio2cpu_rvalid <= 1'b0;
      mmio2cpu_rdata  <= 32'h0;
      mmio2cpu_err    <= 1'b0;
      mmio_addr       <= 29'h0;
      mmio_wren       <= 4'h0;
      mmio_data_in    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu2mmio_valid && cpu2mmio_ready) begin
            cpu2mmio_ready <= 1'b0;
            mmio_addr      <= cpu2mmio_addr;
            mmio_data_in   <= cpu2mmio_wdata;
            wren_q         <= cpu2mmio_wren;
            map_err        <= slot_err;
            cnt            <= CNT_INIT;
            // Single settle cycle: the pulse has to start on the accept edge
            mmio_wren      <= (CNT_INIT == 4'd0 && !slot_err) ? cpu2mmio_wren : 4'h0;
            state          <= ACCESS;
          end else begin
            cpu2mmio_ready <= 1'b1;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            mmio_wren       <= 4'h0;
            mmio2cpu_rdata  <= map_err ? ERR_RDATA : mmio_data_out;
            mmio2cpu_err    <= map_err;
            mmio2cpu_rvalid <= 1'b1;
            state           <= RESP;
          end else begin
            cnt       <= cnt - 4'd1;
            mmio_wren <= (cnt == 4'd1 && !map_err) ? wren_q : 4'h0;
          end
        end
        RESP: begin
          if (mmio2cpu_rready) begin
            mmio2cpu_rvalid <= 1'b0;
            cpu2mmio_ready  <= 1'b1;
            state           <= IDLE;
          end
        end
        default: begin
          mmio_wren <= 4'h0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_soc_mmio_bridge.sv
// Bench for mcpu_soc_mmio_bridge. Two instances are used: settle=1 (u_dut0) and settle=3 (u_dut1).
// Each instance drives a fake register-file decoder.
// A per-instance transaction model predicts every response and every wren pulse.
module tb_mcpu_soc_mmio_bridge;

  logic        clk;
  logic [1:0]  rst_n;
  logic [1:0]  valid, ready, rvalid, rready, err;
  logic [28:0] caddr [2];
  logic [3:0]  cwren [2];
  logic [31:0] cwdata[2];
  logic [31:0] rdata [2];
  logic [28:0] maddr [2];
  logic [3:0]  mwren [2];
  logic [31:0] mdin  [2];
  logic [31:0] dout  [2];

  int vec  = 0;
  int miss = 0;

  mcpu_soc_mmio_bridge #(.SETTLE_CYCLES(1), .MAX_DEV(6), .ERR_RDATA(32'h0)) u_dut0 (
    .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n[0]),
    .cpu2mmio_valid(valid[0]), .cpu2mmio_ready(ready[0]), .cpu2mmio_addr(caddr[0]),
    .cpu2mmio_wren(cwren[0]), .cpu2mmio_wdata(cwdata[0]),
    .mmio2cpu_rvalid(rvalid[0]), .mmio2cpu_rready(rready[0]), .mmio2cpu_rdata(rdata[0]),
    .mmio2cpu_err(err[0]), .mmio_addr(maddr[0]), .mmio_wren(mwren[0]),
    .mmio_data_in(mdin[0]), .mmio_data_out(dout[0]));

  mcpu_soc_mmio_bridge #(.SETTLE_CYCLES(3), .MAX_DEV(6), .ERR_RDATA(32'h0)) u_dut1 (
    .clkrst_core_clk(clk), .clkrst_core_rst_n(rst_n[1]),
    .cpu2mmio_valid(valid[1]), .cpu2mmio_ready(ready[1]), .cpu2mmio_addr(caddr[1]),
    .cpu2mmio_wren(cwren[1]), .cpu2mmio_wdata(cwdata[1]),
    .mmio2cpu_rvalid(rvalid[1]), .mmio2cpu_rready(rready[1]), .mmio2cpu_rdata(rdata[1]),
    .mmio2cpu_err(err[1]), .mmio_addr(maddr[1]), .mmio_wren(mwren[1]),
    .mmio_data_in(mdin[1]), .mmio_data_out(dout[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [6:0] idx(input logic [28:0] a);
    return {a[12:10], a[3:0]};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] w, input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (w[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Fake decoder: 128-word register file, combinational read, byte-enable write on wren
  logic [31:0] dmem [2][128];
  logic        dmem_init = 1'b0;

  // Combinational decoder read; slots above 6 return junk that the bridge must not forward
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      dout[k] = 32'hDEAD_BEEF;
      if (maddr[k][28:10] <= 19'd6) dout[k] = dmem[k][idx(maddr[k])];
    end
  end

  // Decoder register writes
  always @(posedge clk) begin
    if (!dmem_init) begin
      for (int k = 0; k < 2; k++)
        for (int i = 0; i < 128; i++) dmem[k][i] <= 32'h1000_0000 + i;
      dmem[0][1] <= 32'hA5A5_0003;
      dmem[1][1] <= 32'hA5A5_0003;
      dmem_init  <= 1'b1;
    end else begin
      for (int k = 0; k < 2; k++)
        if (mwren[k] != 4'h0) dmem[k][idx(maddr[k])] <= merge(dmem[k][idx(maddr[k])], mwren[k], mdin[k]);
    end
  end

  // Transaction-level model. At most one access is outstanding per bridge.
  logic [31:0] mdl [2][128];
  logic        mdl_init = 1'b0;
  logic        active[2], have_last[2], cur_mapped[2], exp_err[2];
  logic [28:0] cur_addr[2];
  logic [3:0]  cur_w[2];
  logic [31:0] cur_d[2], exp_rd[2];
  int          pulses[2];

  // Compare process: samples two time units after each falling edge, when all signals are settled
  always @(negedge clk) begin
    #2;
    if (!mdl_init) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 128; i++) mdl[k][i] = 32'h1000_0000 + i;
        mdl[k][1] = 32'hA5A5_0003;
        active[k] = 1'b0;
        have_last[k] = 1'b0;
      end
      mdl_init = 1'b1;
    end
    for (int k = 0; k < 2; k++) begin
      if (!rst_n[k]) begin
        active[k]    = 1'b0;
        have_last[k] = 1'b0;
      end else begin
        if (mwren[k] != 4'h0) begin
          if (!active[k] || !cur_mapped[k] || cur_w[k] == 4'h0) chk("spurious_wren", {28'h0, mwren[k]}, 32'h0);
          else begin
            chk("wren_val", {28'h0, mwren[k]}, {28'h0, cur_w[k]});
            chk("wren_data", mdin[k], cur_d[k]);
          end
          pulses[k]++;
        end
        if (have_last[k]) begin
          chk("addr_hold", {3'b0, maddr[k]}, {3'b0, cur_addr[k]});
          chk("data_hold", mdin[k], cur_d[k]);
        end
        if (rvalid[k]) begin
          chk("resp_expected", {31'h0, active[k]}, 32'h1);
          chk("resp_rdata", rdata[k], exp_rd[k]);
          chk("resp_err", {31'h0, err[k]}, {31'h0, exp_err[k]});
          chk("ready_in_resp", {31'h0, ready[k]}, 32'h0);
        end
        if (valid[k] && ready[k]) begin
          active[k]     = 1'b1;
          have_last[k]  = 1'b1;
          pulses[k]     = 0;
          cur_addr[k]   = caddr[k];
          cur_w[k]      = cwren[k];
          cur_d[k]      = cwdata[k];
          cur_mapped[k] = (caddr[k][28:10] <= 19'd6);
          exp_err[k]    = !cur_mapped[k];
          exp_rd[k]     = cur_mapped[k] ? mdl[k][idx(caddr[k])] : 32'h0;
        end else if (rvalid[k] && rready[k]) begin
          chk("pulse_count", pulses[k], (cur_mapped[k] && cur_w[k] != 4'h0) ? 1 : 0);
          if (cur_mapped[k]) mdl[k][idx(cur_addr[k])] = merge(mdl[k][idx(cur_addr[k])], cur_w[k], cur_d[k]);
          active[k] = 1'b0;
        end
      end
    end
  end

  task automatic drive_req(input int k, input logic [28:0] a, input logic [3:0] w, input logic [31:0] d);
    @(negedge clk); #1;
    valid[k] = 1'b1; caddr[k] = a; cwren[k] = w; cwdata[k] = d;
  endtask

  task automatic wait_accept(input int k);
    int n = 0;
    while (!ready[k] && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    if (!ready[k]) begin
      chk("accept_timeout", 32'h0, 32'h1);
      valid[k] = 1'b0;
    end else begin
      @(posedge clk); #1;
      valid[k] = 1'b0;
    end
  endtask

  task automatic start_req(input int k, input logic [28:0] a, input logic [3:0] w, input logic [31:0] d);
    drive_req(k, a, w, d);
    wait_accept(k);
  endtask

  // Count edges from the accept edge (inclusive) until rvalid is seen
  task automatic wait_resp(input int k, output int lat, output logic [31:0] rd, output logic e);
    lat = 1;
    while (!rvalid[k] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!rvalid[k]) chk("resp_timeout", 32'h0, 32'h1);
    rd = rdata[k];
    e  = err[k];
  endtask

  task automatic handshake(input int k);
    @(negedge clk); #1;
    rready[k] = 1'b1;
    @(posedge clk); #1;
    rready[k] = 1'b0;
    chk("rvalid_drop", {31'h0, rvalid[k]}, 32'h0);
  endtask

  task automatic do_req(input int k, input logic [28:0] a, input logic [3:0] w, input logic [31:0] d,
                        output logic [31:0] rd, output logic e, output int lat);
    start_req(k, a, w, d);
    wait_resp(k, lat, rd, e);
    handshake(k);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        e;
    rst_n = 2'b00; valid = 2'b00; rready = 2'b00;
    for (int k = 0; k < 2; k++) begin
      caddr[k] = 29'h0; cwren[k] = 4'h0; cwdata[k] = 32'h0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_ready",  {31'h0, ready[k]}, 32'h0);
      chk("rst_rvalid", {31'h0, rvalid[k]}, 32'h0);
      chk("rst_rdata",  rdata[k], 32'h0);
      chk("rst_err",    {31'h0, err[k]}, 32'h0);
      chk("rst_maddr",  {3'b0, maddr[k]}, 32'h0);
      chk("rst_mwren",  {28'h0, mwren[k]}, 32'h0);
      chk("rst_mdin",   mdin[k], 32'h0);
    end
    #1 rst_n = 2'b11;
    @(negedge clk);
    chk("ready_after_rst", {31'h0, ready[0]}, 32'h1);

    // Read slot 0 word 1
    do_req(0, 29'h1, 4'h0, 32'h0, rd, e, lat);
    chk("t1_rdata", rd, 32'hA5A5_0003);
    chk("t1_err", {31'h0, e}, 32'h0);
    chk("t1_lat", lat, 2);

    // UART write returns the pre-write value; then read back the merged word
    do_req(0, {19'd1, 10'd0}, 4'h1, 32'h41, rd, e, lat);
    chk("t2_prewrite", rd, 32'h1000_0010);
    chk("t2_lat", lat, 2);
    do_req(0, {19'd1, 10'd0}, 4'h0, 32'h0, rd, e, lat);
    chk("t2_readback", rd, 32'h1000_0041);

    // Unmapped slot 7, and slot 6 as the highest valid slot
    do_req(0, {19'd7, 10'd5}, 4'hF, 32'hFFFF_FFFF, rd, e, lat);
    chk("t3_err", {31'h0, e}, 32'h1);
    chk("t3_rdata", rd, 32'h0);
    chk("t3_lat", lat, 2);
    do_req(0, {19'd6, 10'd2}, 4'h0, 32'h0, rd, e, lat);
    chk("t3_slot6_err", {31'h0, e}, 32'h0);
    chk("t3_slot6_rdata", rd, 32'h1000_0062);

    // Response held for 5 cycles while a second request waits
    start_req(0, 29'h1, 4'h0, 32'h0);
    wait_resp(0, lat, rd, e);
    chk("t4_first", rd, 32'hA5A5_0003);
    drive_req(0, {19'd4, 10'd1}, 4'hF, 32'h5555_AAAA);
    repeat (5) begin
      @(negedge clk); #1;
      chk("t4_rvalid_hold", {31'h0, rvalid[0]}, 32'h1);
      chk("t4_rdata_hold", rdata[0], 32'hA5A5_0003);
      chk("t4_ready_low", {31'h0, ready[0]}, 32'h0);
    end
    handshake(0);
    wait_accept(0);
    wait_resp(0, lat, rd, e);
    chk("t4_second", rd, 32'h1000_0041);
    handshake(0);
    do_req(0, {19'd4, 10'd1}, 4'h0, 32'h0, rd, e, lat);
    chk("t4_readback", rd, 32'h5555_AAAA);

    // Three settle cycles
    start_req(1, {19'd3, 10'd9}, 4'hC, 32'hCAFE_BEEF);
    chk("t5_c1_wren", {28'h0, mwren[1]}, 32'h0);
    chk("t5_c1_addr", {3'b0, maddr[1]}, {3'b0, 19'd3, 10'd9});
    @(posedge clk); #1;
    chk("t5_c2_wren", {28'h0, mwren[1]}, 32'h0);
    chk("t5_c2_rvalid", {31'h0, rvalid[1]}, 32'h0);
    @(posedge clk); #1;
    chk("t5_c3_wren", {28'h0, mwren[1]}, 32'hC);
    chk("t5_c3_addr", {3'b0, maddr[1]}, {3'b0, 19'd3, 10'd9});
    @(posedge clk); #1;
    chk("t5_rvalid", {31'h0, rvalid[1]}, 32'h1);
    chk("t5_wren_off", {28'h0, mwren[1]}, 32'h0);
    chk("t5_prewrite", rdata[1], 32'h1000_0039);
    handshake(1);
    do_req(1, {19'd3, 10'd9}, 4'h0, 32'h0, rd, e, lat);
    chk("t5_readback", rd, 32'hCAFE_0039);
    chk("t5_lat", lat, 4);

    // Reset during the write pulse aborts the access
    start_req(0, {19'd2, 10'd3}, 4'h3, 32'h1234_5678);
    chk("t6_pre_wren", {28'h0, mwren[0]}, 32'h3);
    #1 rst_n[0] = 1'b0;
    #1;
    chk("t6_wren_async", {28'h0, mwren[0]}, 32'h0);
    chk("t6_ready", {31'h0, ready[0]}, 32'h0);
    repeat (3) begin
      @(negedge clk); #1;
      chk("t6_no_rvalid", {31'h0, rvalid[0]}, 32'h0);
    end
    rst_n[0] = 1'b1;
    do_req(0, {19'd2, 10'd3}, 4'h0, 32'h0, rd, e, lat);
    chk("t6_after_rst", rd, 32'h1000_0023);
    chk("t6_after_err", {31'h0, e}, 32'h0);

    repeat (3) @(negedge clk);
    #3;
    chk("end_idle0", {31'h0, active[0]}, 32'h0);
    chk("end_idle1", {31'h0, active[1]}, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
